// File: rtl/md_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Pure declarations: no state, no latency.
// No flow control of its own; consumers handle handshakes.
package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } md_state_t;

    // Signed ops work on magnitudes and fix the sign at the end.
    function automatic logic is_signed(md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic is_mul(md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU: radix-2 shift-add multiply, restoring divide.
// Latency: start accepted at t0, done pulses WIDTH+2 cycles later; busy covers it.
// No queueing: start is ignored while busy; cancel aborts and suppresses writeback.
module mul_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    md_state_t          state_q, state_d;
    md_op_t             op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Multiply: {partial product, multiplier}. Divide: low half holds dividend/quotient.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    // Multiplicand or divisor magnitude.
    logic [WIDTH-1:0]   opb_q, opb_d;
    // Original dividend, needed for the divide-by-zero result.
    logic [WIDTH-1:0]   a_orig_q, a_orig_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               op_sgn;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] prod_fix;

    // Next-state, datapath step and output decode for the whole unit.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        opb_d     = opb_q;
        a_orig_d  = a_orig_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done      = 1'b0;

        // Magnitudes of the incoming operands; |MIN| wraps to MIN, read as unsigned.
        op_sgn = is_signed(op);
        abs_a  = (op_sgn && a[WIDTH-1]) ? -a : a;
        abs_b  = (op_sgn && b[WIDTH-1]) ? -b : b;

        // One shift-add step: add multiplicand when the multiplier LSB is set.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);

        // One restoring-divide step: bring down the next dividend bit and trial-subtract.
        rem_sh   = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opb_q};

        prod_fix = neg_quo_q ? -acc_q : acc_q;

        unique case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    op_d      = op;
                    a_orig_d  = a;
                    opb_d     = abs_b;
                    acc_d     = {{WIDTH{1'b0}}, abs_a};
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = op_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = op_sgn && a[WIDTH-1];
                    div0_d    = (b == '0);
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    if (is_mul(op_q)) begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end else if (!rem_diff[WIDTH]) begin
                        rem_d              = rem_diff;
                        acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d              = rem_sh;
                        acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = SIGN;
                    end
                end
            end
            SIGN: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    if (is_mul(op_q)) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else if (div0_q) begin
                        hi_d = a_orig_q;
                        lo_d = '1;
                    end else begin
                        lo_d = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        hi_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = !cancel;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset overrides everything, including mid-operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= MD_MULT;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            opb_q     <= '0;
            a_orig_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            opb_q     <= opb_d;
            a_orig_q  <= a_orig_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
    import md_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s32, c32, busy32, done32;
    md_op_t      op32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        s8, c8, busy8, done8;
    md_op_t      op8;
    logic [7:0]  a8, b8, hi8, lo8;

    mul_div_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(s32), .op(op32), .a(a32), .b(b32),
        .cancel(c32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
    );

    mul_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .op(op8), .a(a8), .b(b8),
        .cancel(c8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          issue;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && done32 === 1'b1) begin
            if (q32.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done32_unexpected: got done with hi=%h lo=%h, expected no done", hi32, lo32);
            end else begin
                e = q32.pop_front();
                check("hi32", hi32, e.hi);
                check("lo32", lo32, e.lo);
                check("latency32", 32'(cyc - e.issue), 32'd34);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && done8 === 1'b1) begin
            if (q8.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done8_unexpected: got done with hi=%h lo=%h, expected no done", hi8, lo8);
            end else begin
                e = q8.pop_front();
                check("hi8", {24'd0, hi8}, e.hi);
                check("lo8", {24'd0, lo8}, e.lo);
                check("latency8", 32'(cyc - e.issue), 32'd10);
            end
        end
    end

    task automatic issue32(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input bit push);
        @(posedge clk); #1;
        s32 = 1'b1; op32 = op; a32 = a; b32 = b;
        if (push) q32.push_back('{hi: ehi, lo: elo, issue: cyc});
        @(posedge clk); #1;
        s32 = 1'b0;
    endtask

    task automatic issue8(input md_op_t op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ehi, input logic [7:0] elo);
        @(posedge clk); #1;
        s8 = 1'b1; op8 = op; a8 = a; b8 = b;
        q8.push_back('{hi: {24'd0, ehi}, lo: {24'd0, elo}, issue: cyc});
        @(posedge clk); #1;
        s8 = 1'b0;
    endtask

    task automatic wait_idle32(input int max);
        int k = 0;
        while (busy32 !== 1'b0 && k < max) begin
            @(negedge clk);
            k++;
        end
        if (busy32 !== 1'b0) check("wait_idle32_timeout", {31'd0, busy32}, 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_idle8(input int max);
        int k = 0;
        while (busy8 !== 1'b0 && k < max) begin
            @(negedge clk);
            k++;
        end
        if (busy8 !== 1'b0) check("wait_idle8_timeout", {31'd0, busy8}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        rst = 1'b1;
        s32 = 1'b0; c32 = 1'b0; op32 = MD_MULT; a32 = '0; b32 = '0;
        s8  = 1'b0; c8  = 1'b0; op8  = MD_MULT; a8  = '0; b8  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy32", {31'd0, busy32}, 32'd0);
        check("rst_done32", {31'd0, done32}, 32'd0);
        check("rst_hi32", hi32, 32'd0);
        check("rst_lo32", lo32, 32'd0);
        check("rst_busy8", {31'd0, busy8}, 32'd0);
        check("rst_hilo8", {16'd0, hi8, lo8}, 32'd0);

        // Signed multiply, plus busy duration
        issue32(MD_MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1);
        bc = 0;
        while (busy32 === 1'b1 && bc < 100) begin
            @(negedge clk);
            if (busy32 === 1'b1) bc++;
        end
        check("busy_cycles32", 32'(bc), 32'd34);
        @(negedge clk);

        issue32(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
        wait_idle32(100);
        issue32(MD_DIVU, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b1);
        wait_idle32(100);
        issue32(MD_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
        wait_idle32(100);
        issue32(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b1);
        wait_idle32(100);

        // Divide by zero, with a second start while busy that must be ignored
        issue32(MD_DIV, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
        repeat (5) @(posedge clk);
        #1 s32 = 1'b1; op32 = MD_MULTU; a32 = 32'd3; b32 = 32'd4;
        @(posedge clk); #1 s32 = 1'b0;
        wait_idle32(100);
        repeat (3) @(negedge clk);
        check("ignored_start_busy32", {31'd0, busy32}, 32'd0);
        check("ignored_start_hi32", hi32, 32'hFFFFFFF9);
        check("ignored_start_lo32", lo32, 32'hFFFFFFFF);

        // Preload hi/lo = 1/2, then cancel a DIVU mid-CALC
        issue32(MD_DIVU, 32'd5, 32'd2, 32'd1, 32'd2, 1'b1);
        wait_idle32(100);
        issue32(MD_DIVU, 32'd9, 32'd2, 32'd0, 32'd0, 1'b0);
        repeat (8) @(posedge clk);
        #1 c32 = 1'b1;
        @(posedge clk); #1 c32 = 1'b0;
        @(negedge clk);
        check("cancel_busy32", {31'd0, busy32}, 32'd0);
        check("cancel_hi32", hi32, 32'd1);
        check("cancel_lo32", lo32, 32'd2);
        repeat (40) @(negedge clk);
        check("cancel_hold_hi32", hi32, 32'd1);
        check("cancel_hold_lo32", lo32, 32'd2);

        // Reset mid-CALC
        issue32(MD_DIVU, 32'd9, 32'd2, 32'd0, 32'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy32", {31'd0, busy32}, 32'd0);
        check("midrst_hi32", hi32, 32'd0);
        check("midrst_lo32", lo32, 32'd0);
        repeat (40) @(negedge clk);
        check("midrst_hold_busy32", {31'd0, busy32}, 32'd0);

        // start and cancel together in IDLE
        @(posedge clk); #1;
        s32 = 1'b1; c32 = 1'b1; op32 = MD_MULTU; a32 = 32'd7; b32 = 32'd7;
        @(posedge clk); #1 s32 = 1'b0; c32 = 1'b0;
        @(negedge clk);
        check("start_cancel_busy32", {31'd0, busy32}, 32'd0);
        repeat (3) @(negedge clk);
        check("start_cancel_busy32_later", {31'd0, busy32}, 32'd0);

        // Narrow instance
        issue8(MD_MULT, 8'h80, 8'h80, 8'h40, 8'h00);
        wait_idle8(40);
        issue8(MD_DIV, 8'h80, 8'hFF, 8'h00, 8'h80);
        wait_idle8(40);
        issue8(MD_MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01);
        wait_idle8(40);
        issue8(MD_DIVU, 8'h0D, 8'h00, 8'h0D, 8'hFF);
        wait_idle8(40);

        repeat (5) @(negedge clk);
        check("q32_drained", 32'(q32.size()), 32'd0);
        check("q8_drained", 32'(q8.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
